// File: rtl/gba_dma_channel.sv
// gba_dma_channel: single GBA DMA channel copying halfwords/words as a bus initiator,
// configured through SAD/DAD/CNT_L/CNT_H registers, with a one-cycle completion irq.
module gba_dma_channel #(
  parameter int COUNT_BITS = 14,
  parameter int ADDR_BITS = 28
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reg_we,
  input  logic [1:0]  reg_sel,
  input  logic [31:0] reg_wdata,
  input  logic        trigger,
  output logic        bus_req,
  output logic        bus_we,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready,
  output logic        irq,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, WAIT, READ, WRITE, DONE} state_t;
  state_t state, state_n;
  logic [31:0] sad, dad, data, data_n;
  logic [15:0] cnt_h, half;
  logic [COUNT_BITS-1:0] cnt_l, count, count_n;
  logic [ADDR_BITS-1:0] src, dst, src_n, dst_n, step, src_step, dst_step;
  logic [1:0] sa, da;
  logic en, word, immediate, cnt_h_wr, latch, clr_en, acc_n, unused_bits;

  function automatic logic [ADDR_BITS-1:0] align(input logic [31:0] a, input logic w);
    return a[ADDR_BITS-1:0] & ~ADDR_BITS'(w ? 3 : 1);
  endfunction

  assign en = cnt_h[15];
  assign word = cnt_h[10];
  assign immediate = cnt_h[13:12] == 2'b00;
  assign sa = cnt_h[8:7];
  assign da = cnt_h[6:5];
  assign cnt_h_wr = reg_we && reg_sel == 2'd3;
  assign latch = cnt_h_wr && reg_wdata[15] && !en;
  assign half = src[1] ? bus_rdata[31:16] : bus_rdata[15:0];
  assign step = word ? ADDR_BITS'(4) : ADDR_BITS'(2);
  assign src_step = sa == 2'b00 ? src + step : sa == 2'b01 ? src - step : src;
  assign dst_step = da == 2'b01 ? dst - step : da == 2'b10 ? dst : dst + step;
  assign acc_n = state_n == READ || state_n == WRITE;
  assign unused_bits = ^{sad, dad, cnt_h[4:0], cnt_h[11], reg_wdata};

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;

  always_comb begin
    state_n = state;
    src_n = src;
    dst_n = dst;
    count_n = count;
    data_n = data;
    clr_en = 1'b0;
    case (state)
      WAIT: state_n = !en ? IDLE : (immediate || trigger) ? READ : WAIT;
      READ: if (bus_ready) begin
        data_n = word ? bus_rdata : {2{half}};
        state_n = en ? WRITE : IDLE;
      end
      WRITE: if (bus_ready) begin
        if (!en) state_n = IDLE;
        else begin
          src_n = src_step;
          dst_n = dst_step;
          count_n = count - COUNT_BITS'(1);
          state_n = count == COUNT_BITS'(1) ? DONE : READ;
        end
      end
      DONE: if (en && cnt_h[9] && !immediate) begin
        count_n = cnt_l;
        dst_n = da == 2'b11 ? align(dad, word) : dst;
        state_n = WAIT;
      end else begin
        clr_en = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // the latch uses the size being written so alignment matches the new transfer
    if (latch) begin
      src_n = align(sad, reg_wdata[10]);
      dst_n = align(dad, reg_wdata[10]);
      count_n = cnt_l;
      state_n = WAIT;
    end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sad <= '0;
      dad <= '0;
      cnt_l <= '0;
      cnt_h <= '0;
      src <= '0;
      dst <= '0;
      count <= '0;
      data <= '0;
      bus_req <= 1'b0;
      bus_we <= 1'b0;
      bus_size <= 2'b00;
      bus_addr <= '0;
      bus_wdata <= '0;
      irq <= 1'b0;
      busy <= 1'b0;
    end else begin
      src <= src_n;
      dst <= dst_n;
      count <= count_n;
      data <= data_n;
      if (reg_we && reg_sel == 2'd0) sad <= reg_wdata;
      if (reg_we && reg_sel == 2'd1) dad <= reg_wdata;
      if (reg_we && reg_sel == 2'd2) cnt_l <= reg_wdata[COUNT_BITS-1:0];
      if (cnt_h_wr) cnt_h <= reg_wdata[15:0];
      else if (clr_en) cnt_h[15] <= 1'b0;
      bus_req <= acc_n;
      irq <= state_n == DONE && cnt_h[14];
      busy <= state_n != IDLE;
      // bus fields only move when a new access starts, so they hold through wait states
      if (acc_n && state_n != state) begin
        bus_we <= state_n == WRITE;
        bus_size <= word ? 2'b10 : 2'b01;
        bus_addr <= 32'(state_n == WRITE ? dst_n : src_n);
        bus_wdata <= data_n;
      end
    end
endmodule

// File: tb/tb_gba_dma_channel.sv
// tb_gba_dma_channel: directed stimulus with a queue of expected bus accesses and irqs,
// checked by an independent monitor against a simple memory responder.
module tb_gba_dma_channel;
  logic clk = 1'b0, reset = 1'b1, reg_we = 1'b0, trigger = 1'b0, bus_ready = 1'b0;
  logic [1:0] reg_sel = 2'b00;
  logic [31:0] reg_wdata = '0, bus_rdata = '0;
  logic bus_req, bus_we, irq, busy;
  logic [1:0] bus_size;
  logic [31:0] bus_addr, bus_wdata;
  typedef struct {int kind; logic [31:0] addr; logic [31:0] data; logic [1:0] size; int gap;} ev_t;
  ev_t q[$];
  int vectors = 0, miscompares = 0, cyc = 0, last_cyc = 0, waits = 0, wcnt = 0;
  logic hold = 1'b0, stall_prev = 1'b0;
  logic [66:0] snap = '0;

  always #5 clk = ~clk;

  gba_dma_channel #(.COUNT_BITS(4), .ADDR_BITS(28)) dut (
    .clk(clk), .reset(reset), .reg_we(reg_we), .reg_sel(reg_sel), .reg_wdata(reg_wdata),
    .trigger(trigger), .bus_req(bus_req), .bus_we(bus_we), .bus_size(bus_size),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ready(bus_ready), .irq(irq), .busy(busy)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0] ^ 16'h1234, a[15:0] ^ 16'hABCD};
  endfunction

  function automatic logic [31:0] hrep(input logic [31:0] a);
    logic [31:0] w;
    w = mem(a);
    return a[1] ? {2{w[31:16]}} : {2{w[15:0]}};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic pop(input int kind);
    ev_t e;
    logic ok;
    vectors++;
    if (q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_event: kind %0d addr %h at cycle %0d, none required", kind, bus_addr, cyc);
      return;
    end
    e = q.pop_front();
    ok = e.kind == kind && (kind == 2 || (bus_addr == e.addr && bus_size == e.size &&
         (kind == 0 || bus_wdata == e.data))) && (e.gap == 0 || cyc - last_cyc == e.gap);
    if (!ok) begin
      miscompares++;
      $display("FAIL event: got kind %0d addr %h size %b wdata %h gap %0d, required kind %0d addr %h size %b wdata %h gap %0d",
               kind, bus_addr, bus_size, bus_wdata, cyc - last_cyc, e.kind, e.addr, e.size, e.data, e.gap);
    end
    last_cyc = cyc;
  endtask

  task automatic exp_r(input logic [31:0] a, input logic [1:0] s, input int g);
    q.push_back('{0, a, 32'd0, s, g});
  endtask

  task automatic exp_w(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s, input int g);
    q.push_back('{1, a, d, s, g});
  endtask

  task automatic exp_irq();
    q.push_back('{2, 32'd0, 32'd0, 2'b00, 1});
  endtask

  task automatic wr(input logic [1:0] sel, input logic [31:0] d);
    @(negedge clk);
    reg_we = 1'b1;
    reg_sel = sel;
    reg_wdata = d;
    @(negedge clk);
    reg_we = 1'b0;
  endtask

  task automatic setup(input logic [31:0] s, input logic [31:0] d, input logic [31:0] n, input logic [31:0] c);
    wr(2'd0, s);
    wr(2'd1, d);
    wr(2'd2, n);
    wr(2'd3, c);
  endtask

  task automatic pulse();
    @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit && q.size() != 0; i++) @(negedge clk);
    chk("drain_pending", q.size(), 0);
  endtask

  // responder: ready after `waits` low cycles per access, data from the mem() pattern
  always @(posedge clk) begin
    #1;
    if (bus_req && !hold && wcnt >= waits) begin
      bus_ready = 1'b1;
      wcnt = 0;
    end else begin
      bus_ready = 1'b0;
      wcnt = bus_req ? wcnt + 1 : 0;
    end
    bus_rdata = mem(bus_addr);
  end

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (stall_prev) chk("stable_during_wait", {bus_we, bus_size, bus_addr, bus_wdata}, snap);
      if (bus_req && bus_ready) pop(bus_we ? 1 : 0);
      if (irq) pop(2);
      stall_prev = bus_req && !bus_ready;
      snap = {bus_we, bus_size, bus_addr, bus_wdata};
    end else stall_prev = 1'b0;
  end

  initial begin
    logic [31:0] a;
    cycles(3);
    chk("reset_outputs", {bus_req, bus_we, bus_size, bus_addr, bus_wdata, irq, busy}, 0);
    reset = 1'b0;
    // immediate word copy, both incrementing
    for (int i = 0; i < 4; i++) begin
      exp_r(32'h0200_0000 + 32'(4 * i), 2'b10, i == 0 ? 0 : 1);
      exp_w(32'h0300_0000 + 32'(4 * i), mem(32'h0200_0000 + 32'(4 * i)), 2'b10, 1);
    end
    exp_irq();
    setup(32'h0200_0000, 32'h0300_0000, 4, 32'hC400);
    drain(100);
    cycles(2);
    chk("word_busy_low", busy, 0);
    // halfword, src decrement, dst fixed
    for (int i = 0; i < 3; i++) begin
      a = 32'h0200_000E - 32'(2 * i);
      exp_r(a, 2'b01, i == 0 ? 0 : 1);
      exp_w(32'h0300_0100, hrep(a), 2'b01, 1);
    end
    exp_irq();
    setup(32'h0200_000E, 32'h0300_0100, 3, 32'hC0C0);
    drain(100);
    // three wait states per access
    waits = 3;
    for (int i = 0; i < 2; i++) begin
      exp_r(32'h0200_0100 + 32'(4 * i), 2'b10, i == 0 ? 0 : 4);
      exp_w(32'h0300_0200 + 32'(4 * i), mem(32'h0200_0100 + 32'(4 * i)), 2'b10, 4);
    end
    exp_irq();
    setup(32'h0200_0100, 32'h0300_0200, 2, 32'hC400);
    drain(100);
    waits = 0;
    // repeat on trigger, dst reload, src continues
    setup(32'h0200_0200, 32'h0300_0300, 2, 32'hD660);
    cycles(6);
    chk("no_req_before_trigger", bus_req, 0);
    chk("waiting_busy", busy, 1);
    for (int i = 0; i < 2; i++) begin
      exp_r(32'h0200_0200 + 32'(4 * i), 2'b10, i == 0 ? 0 : 1);
      exp_w(32'h0300_0300 + 32'(4 * i), mem(32'h0200_0200 + 32'(4 * i)), 2'b10, 1);
    end
    exp_irq();
    pulse();
    cycles(1);
    pulse();
    drain(40);
    cycles(4);
    chk("trigger_not_queued", bus_req, 0);
    for (int i = 0; i < 2; i++) begin
      exp_r(32'h0200_0208 + 32'(4 * i), 2'b10, i == 0 ? 0 : 1);
      exp_w(32'h0300_0300 + 32'(4 * i), mem(32'h0200_0208 + 32'(4 * i)), 2'b10, 1);
    end
    exp_irq();
    pulse();
    drain(40);
    wr(2'd3, 32'h0);
    cycles(3);
    chk("repeat_disabled_idle", busy, 0);
    // count 0 means 16 units with a 4-bit counter
    for (int i = 0; i < 16; i++) begin
      a = 32'h0200_0400 + 32'(2 * i);
      exp_r(a, 2'b01, i == 0 ? 0 : 1);
      exp_w(32'h0300_0400 + 32'(2 * i), hrep(a), 2'b01, 1);
    end
    exp_irq();
    setup(32'h0200_0400, 32'h0300_0400, 0, 32'hC000);
    drain(200);
    // abort during a stalled read
    hold = 1'b1;
    exp_r(32'h0200_0500, 2'b10, 0);
    setup(32'h0200_0500, 32'h0300_0500, 3, 32'hC400);
    for (int i = 0; i < 20 && !bus_req; i++) @(negedge clk);
    wr(2'd3, 32'h4400);
    cycles(3);
    chk("abort_req_held", bus_req, 1);
    hold = 1'b0;
    drain(20);
    cycles(3);
    chk("abort_idle", {bus_req, busy}, 0);
    // async reset while a write is stalled
    waits = 5;
    exp_r(32'h0200_0600, 2'b10, 0);
    setup(32'h0200_0600, 32'h0300_0600, 1, 32'h8400);
    for (int i = 0; i < 60 && !(bus_req && bus_we); i++) @(negedge clk);
    chk("reach_write", {bus_req, bus_we}, 2'b11);
    drain(5);
    #3 reset = 1'b1;
    #1 chk("reset_mid_write", {bus_req, bus_we, bus_size, bus_addr, bus_wdata, irq, busy}, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
